// File: rtl/nios2_cpu_cpu_debug_cmd_bridge.sv
// Debug command bridge: synchronises per-channel JTAG update events into clk,
// holds one pending command per channel and round-robins them onto one port.
module nios2_cpu_cpu_debug_cmd_bridge #(
  parameter int NUM_CH      = 2,
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        ch_udr,
  input  logic [NUM_CH-1:0]        ch_uir,
  input  logic [NUM_CH*IR_W-1:0]   ch_ir,
  input  logic [NUM_CH*SR_W-1:0]   ch_sr,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [CH_W-1:0]          cmd_ch,
  output logic                     cmd_kind,
  output logic [IR_W-1:0]          cmd_ir,
  output logic [SR_W-1:0]          cmd_data,
  output logic [NUM_CH-1:0]        overrun,
  input  logic [NUM_CH-1:0]        overrun_clr,
  output logic                     busy
);

  logic [NUM_CH-1:0] r_udr_sync [SYNC_STAGES];
  logic [NUM_CH-1:0] r_uir_sync [SYNC_STAGES];
  logic [NUM_CH-1:0] r_udr_prev, r_uir_prev;
  logic [NUM_CH-1:0] r_udr_edge, r_uir_edge;

  logic [NUM_CH-1:0] r_slot_v;
  logic [NUM_CH-1:0] r_slot_kind;
  logic [IR_W-1:0]   r_slot_ir   [NUM_CH];
  logic [SR_W-1:0]   r_slot_data [NUM_CH];
  logic [NUM_CH-1:0] r_overrun;

  logic              r_cmd_valid;
  logic [CH_W-1:0]   r_cmd_ch;
  logic              r_cmd_kind;
  logic [IR_W-1:0]   r_cmd_ir;
  logic [SR_W-1:0]   r_cmd_data;
  logic [CH_W-1:0]   r_rr_ptr;

  logic [CH_W-1:0]   w_winner;
  logic              w_any;
  logic              w_load;
  logic [NUM_CH-1:0] w_drain;
  logic [NUM_CH-1:0] w_ovr_set;
  logic [CH_W-1:0]   w_rr_next;

  // Stage: synchronisers and registered rising-edge detect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_udr_sync[s] <= '0;
        r_uir_sync[s] <= '0;
      end
      r_udr_prev <= '0;
      r_uir_prev <= '0;
      r_udr_edge <= '0;
      r_uir_edge <= '0;
    end else begin
      r_udr_sync[0] <= ch_udr;
      r_uir_sync[0] <= ch_uir;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_udr_sync[s] <= r_udr_sync[s-1];
        r_uir_sync[s] <= r_uir_sync[s-1];
      end
      r_udr_prev <= r_udr_sync[SYNC_STAGES-1];
      r_uir_prev <= r_uir_sync[SYNC_STAGES-1];
      r_udr_edge <= r_udr_sync[SYNC_STAGES-1] & ~r_udr_prev;
      r_uir_edge <= r_uir_sync[SYNC_STAGES-1] & ~r_uir_prev;
    end
  end

  // Round-robin search: first valid slot at offset 0..NUM_CH-1 from r_rr_ptr
  always_comb begin
    w_winner = '0;
    w_any    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (!w_any && r_slot_v[k] && (((int'(r_rr_ptr) + i) % NUM_CH) == k)) begin
          w_any    = 1'b1;
          w_winner = CH_W'(k);
        end
      end
    end
  end

  assign w_load    = w_any & (~r_cmd_valid | cmd_ready);
  assign w_rr_next = (w_winner == CH_W'(NUM_CH-1)) ? '0 : w_winner + 1'b1;

  always_comb begin
    w_drain = '0;
    for (int k = 0; k < NUM_CH; k++)
      w_drain[k] = w_load && (w_winner == CH_W'(k));
  end

  // A simultaneous IR edge is always lost because DR takes the slot
  assign w_ovr_set = (r_udr_edge & r_uir_edge)
                   | ((r_udr_edge | r_uir_edge) & r_slot_v & ~w_drain);

  // Stage: per-channel pending slots and sticky overrun
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_slot_v    <= '0;
      r_slot_kind <= '0;
      r_overrun   <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_slot_ir[k]   <= '0;
        r_slot_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if ((r_udr_edge[k] | r_uir_edge[k]) && (!r_slot_v[k] || w_drain[k])) begin
          r_slot_v[k]    <= 1'b1;
          r_slot_kind[k] <= ~r_udr_edge[k];
          r_slot_ir[k]   <= ch_ir[k*IR_W +: IR_W];
          r_slot_data[k] <= r_udr_edge[k] ? ch_sr[k*SR_W +: SR_W] : '0;
        end else if (w_drain[k]) begin
          r_slot_v[k] <= 1'b0;
        end
        r_overrun[k] <= w_ovr_set[k] | (r_overrun[k] & ~overrun_clr[k]);
      end
    end
  end

  // Stage: output command register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd_valid <= 1'b0;
      r_cmd_ch    <= '0;
      r_cmd_kind  <= 1'b0;
      r_cmd_ir    <= '0;
      r_cmd_data  <= '0;
      r_rr_ptr    <= '0;
    end else if (w_load) begin
      r_cmd_valid <= 1'b1;
      r_cmd_ch    <= w_winner;
      r_cmd_kind  <= r_slot_kind[w_winner];
      r_cmd_ir    <= r_slot_ir[w_winner];
      r_cmd_data  <= r_slot_data[w_winner];
      r_rr_ptr    <= w_rr_next;
    end else if (cmd_ready) begin
      r_cmd_valid <= 1'b0;
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_ch    = r_cmd_ch;
  assign cmd_kind  = r_cmd_kind;
  assign cmd_ir    = r_cmd_ir;
  assign cmd_data  = r_cmd_data;
  assign overrun   = r_overrun;
  assign busy      = (|r_slot_v) | r_cmd_valid;

endmodule

// File: tb/tb_nios2_cpu_cpu_debug_cmd_bridge.sv
// Directed + randomized bench for the debug command bridge; the random phase
// checks every handshake against a per-channel expected-command scoreboard.
module tb_nios2_cpu_cpu_debug_cmd_bridge;
  localparam int NUM_CH = 2, SR_W = 38, IR_W = 2, SYNC_STAGES = 2, CH_W = 1;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic [NUM_CH-1:0]      ch_udr = '0, ch_uir = '0;
  logic [NUM_CH*IR_W-1:0] ch_ir = '0;
  logic [NUM_CH*SR_W-1:0] ch_sr = '0;
  logic                   cmd_ready = 1'b0;
  logic [NUM_CH-1:0]      overrun_clr = '0;
  logic                   cmd_valid, cmd_kind, busy;
  logic [CH_W-1:0]        cmd_ch;
  logic [IR_W-1:0]        cmd_ir;
  logic [SR_W-1:0]        cmd_data;
  logic [NUM_CH-1:0]      overrun;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic            kind;
    logic [IR_W-1:0] ir;
    logic [SR_W-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic            mon_en = 1'b0;
  logic            stall_prev = 1'b0;
  logic [CH_W-1:0] held_ch;
  logic            held_kind;
  logic [IR_W-1:0] held_ir;
  logic [SR_W-1:0] held_data;
  int              mon_hit;

  nios2_cpu_cpu_debug_cmd_bridge #(
    .NUM_CH(NUM_CH), .SR_W(SR_W), .IR_W(IR_W), .SYNC_STAGES(SYNC_STAGES), .CH_W(CH_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ch_udr(ch_udr), .ch_uir(ch_uir), .ch_ir(ch_ir),
    .ch_sr(ch_sr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch),
    .cmd_kind(cmd_kind), .cmd_ir(cmd_ir), .cmd_data(cmd_data), .overrun(overrun),
    .overrun_clr(overrun_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_ch(input int k, input logic [IR_W-1:0] ir, input logic [SR_W-1:0] sr);
    ch_ir[k*IR_W +: IR_W] = ir;
    ch_sr[k*SR_W +: SR_W] = sr;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 12 && !cmd_valid; i++) tick();
    chk(tag, 64'(cmd_valid), 64'd1);
  endtask

  // Scoreboard monitor for the random phase
  always @(negedge clk) begin
    if (mon_en) begin
      if (stall_prev) begin
        chk("hold_valid", 64'(cmd_valid), 64'd1);
        chk("hold_ch",    64'(cmd_ch),    64'(held_ch));
        chk("hold_kind",  64'(cmd_kind),  64'(held_kind));
        chk("hold_ir",    64'(cmd_ir),    64'(held_ir));
        chk("hold_data",  64'(cmd_data),  64'(held_data));
      end
      if (cmd_valid && cmd_ready) begin
        mon_hit = -1;
        for (int i = 0; i < exp_q.size(); i++)
          if (mon_hit < 0 && exp_q[i].ch == cmd_ch) mon_hit = i;
        chk("sb_expected", 64'(mon_hit >= 0), 64'd1);
        if (mon_hit >= 0) begin
          chk("sb_kind", 64'(cmd_kind), 64'(exp_q[mon_hit].kind));
          chk("sb_ir",   64'(cmd_ir),   64'(exp_q[mon_hit].ir));
          chk("sb_data", 64'(cmd_data), 64'(exp_q[mon_hit].data));
          exp_q.delete(mon_hit);
        end
        chk("sb_overrun", 64'(overrun), 64'd0);
      end
      stall_prev = cmd_valid && !cmd_ready;
      held_ch = cmd_ch; held_kind = cmd_kind; held_ir = cmd_ir; held_data = cmd_data;
    end
  end

  initial begin
    logic [127:0]    rnd;
    logic [63:0]     r64;
    logic [NUM_CH-1:0] mask;
    logic            kd;
    logic [IR_W-1:0] ir;
    logic [SR_W-1:0] sr;
    exp_t            e;

    // Reset with random inputs
    for (int i = 0; i < 5; i++) begin
      rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
      ch_udr = rnd[1:0]; ch_uir = rnd[3:2]; ch_ir = rnd[7:4];
      ch_sr = rnd[NUM_CH*SR_W+7:8]; cmd_ready = rnd[100]; overrun_clr = rnd[102:101];
      tick();
    end
    chk("rst_valid", 64'(cmd_valid), 64'd0);
    chk("rst_ch",    64'(cmd_ch),    64'd0);
    chk("rst_kind",  64'(cmd_kind),  64'd0);
    chk("rst_ir",    64'(cmd_ir),    64'd0);
    chk("rst_data",  64'(cmd_data),  64'd0);
    chk("rst_ovr",   64'(overrun),   64'd0);
    chk("rst_busy",  64'(busy),      64'd0);
    ch_udr = '0; ch_uir = '0; ch_ir = '0; ch_sr = '0; cmd_ready = 1'b0; overrun_clr = '0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_valid", 64'(cmd_valid), 64'd0);
      chk("idle_busy",  64'(busy),      64'd0);
    end

    // Single DR latency: edge sampled at clock 0, cmd_valid after clock 4
    set_ch(0, 2'b01, 38'h2A_DEAD_BEEF);
    cmd_ready = 1'b1;
    ch_udr[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("lat_early_valid", 64'(cmd_valid), 64'd0);
    end
    chk("lat_slot_busy", 64'(busy), 64'd1);
    tick();
    chk("lat_valid", 64'(cmd_valid), 64'd1);
    chk("lat_ch",    64'(cmd_ch),    64'd0);
    chk("lat_kind",  64'(cmd_kind),  64'd0);
    chk("lat_ir",    64'(cmd_ir),    64'd1);
    chk("lat_data",  64'(cmd_data),  64'h2A_DEAD_BEEF);
    tick();
    chk("lat_one_clk", 64'(cmd_valid), 64'd0);
    ch_udr[0] = 1'b0;
    ticks(4);

    // IR event on channel 1 (also returns rr_ptr to 0)
    set_ch(1, 2'b10, 38'h15_1234_5678);
    ch_uir[1] = 1'b1;
    wait_valid("ir_timeout");
    chk("ir_ch",   64'(cmd_ch),   64'd1);
    chk("ir_kind", 64'(cmd_kind), 64'd1);
    chk("ir_ir",   64'(cmd_ir),   64'd2);
    chk("ir_data", 64'(cmd_data), 64'd0);
    tick();
    chk("ir_done", 64'(cmd_valid), 64'd0);
    ch_uir[1] = 1'b0;
    ticks(4);

    // Round-robin: both channels together, twice
    for (int rep = 0; rep < 2; rep++) begin
      set_ch(0, 2'b01, 38'h01_0000_1000 + 38'(rep));
      set_ch(1, 2'b11, 38'h02_0000_2000 + 38'(rep));
      ch_udr = 2'b11;
      wait_valid("rr_timeout");
      chk("rr_first_ch",   64'(cmd_ch),   64'd0);
      chk("rr_first_data", 64'(cmd_data), 64'h01_0000_1000 + 64'(rep));
      tick();
      chk("rr_second_valid", 64'(cmd_valid), 64'd1);
      chk("rr_second_ch",    64'(cmd_ch),    64'd1);
      chk("rr_second_data",  64'(cmd_data),  64'h02_0000_2000 + 64'(rep));
      tick();
      chk("rr_done", 64'(cmd_valid), 64'd0);
      ch_udr = '0;
      ticks(4);
    end

    // Backpressure and overrun on channel 0: A out, B held, C dropped
    cmd_ready = 1'b0;
    set_ch(0, 2'b00, 38'h0A_AAAA_AAAA);
    ch_udr[0] = 1'b1;
    wait_valid("bp_a_timeout");
    chk("bp_a_data", 64'(cmd_data), 64'h0A_AAAA_AAAA);
    ch_udr[0] = 1'b0; ticks(4);
    set_ch(0, 2'b00, 38'h0B_BBBB_BBBB);
    ch_udr[0] = 1'b1; ticks(5);
    chk("bp_b_no_ovr", 64'(overrun),  64'd0);
    chk("bp_b_hold_a", 64'(cmd_data), 64'h0A_AAAA_AAAA);
    ch_udr[0] = 1'b0; ticks(4);
    set_ch(0, 2'b00, 38'h0C_CCCC_CCCC);
    ch_udr[0] = 1'b1; ticks(5);
    chk("bp_c_ovr",    64'(overrun),   64'd1);
    chk("bp_c_valid",  64'(cmd_valid), 64'd1);
    chk("bp_c_hold_a", 64'(cmd_data),  64'h0A_AAAA_AAAA);
    cmd_ready = 1'b1;
    tick();
    chk("bp_b_valid", 64'(cmd_valid), 64'd1);
    chk("bp_b_data",  64'(cmd_data),  64'h0B_BBBB_BBBB);
    tick();
    chk("bp_c_dropped", 64'(cmd_valid), 64'd0);
    chk("bp_idle_busy", 64'(busy),      64'd0);
    ch_udr[0] = 1'b0;
    overrun_clr = 2'b01;
    tick();
    overrun_clr = '0;
    chk("bp_ovr_clr", 64'(overrun), 64'd0);
    ticks(3);

    // Overrun set coincides with overrun_clr on channel 1
    cmd_ready = 1'b0;
    set_ch(1, 2'b01, 38'h11_1111_1111);
    ch_udr[1] = 1'b1;
    wait_valid("sc_x_timeout");
    chk("sc_x_data", 64'(cmd_data), 64'h11_1111_1111);
    ch_udr[1] = 1'b0; ticks(4);
    set_ch(1, 2'b10, 38'h22_2222_2222);
    ch_udr[1] = 1'b1; ticks(5);
    chk("sc_y_no_ovr", 64'(overrun), 64'd0);
    ch_udr[1] = 1'b0; ticks(4);
    set_ch(1, 2'b11, 38'h33_3333_3333);
    ch_udr[1] = 1'b1;
    ticks(3);
    overrun_clr = 2'b10;
    tick();
    overrun_clr = '0;
    chk("sc_set_wins", 64'(overrun),  64'h2);
    chk("sc_x_held",   64'(cmd_data), 64'h11_1111_1111);

    // Reset mid-operation with both slots pending and a stalled command
    set_ch(0, 2'b01, 38'h3F_0F0F_0F0F);
    ch_udr[0] = 1'b1; ticks(5);
    chk("mid_busy", 64'(busy), 64'd1);
    ch_udr = '0; ch_uir = '0;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(cmd_valid), 64'd0);
    chk("mid_rst_busy",  64'(busy),      64'd0);
    chk("mid_rst_ovr",   64'(overrun),   64'd0);
    tick();
    reset_n = 1'b1;
    cmd_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("mid_no_stale_valid", 64'(cmd_valid), 64'd0);
      chk("mid_no_stale_busy",  64'(busy),      64'd0);
    end

    // Random phase: scoreboarded events with random backpressure
    stall_prev = 1'b0;
    mon_en = 1'b1;
    for (int r = 0; r < 40; r++) begin
      mask = NUM_CH'($urandom_range(1, 3));
      for (int k = 0; k < NUM_CH; k++) begin
        if (mask[k]) begin
          kd  = 1'($urandom_range(0, 1));
          ir  = IR_W'($urandom_range(0, 3));
          r64 = {$urandom(), $urandom()};
          sr  = r64[SR_W-1:0];
          set_ch(k, ir, sr);
          e.ch = CH_W'(k); e.kind = kd; e.ir = ir; e.data = kd ? {SR_W{1'b0}} : sr;
          exp_q.push_back(e);
          if (kd) ch_uir[k] = 1'b1;
          else    ch_udr[k] = 1'b1;
        end
      end
      for (int i = 0; i < 4; i++) begin
        cmd_ready = 1'($urandom_range(0, 1));
        tick();
      end
      ch_udr = '0; ch_uir = '0;
      for (int i = 0; i < 60 && (busy || cmd_valid); i++) begin
        cmd_ready = 1'($urandom_range(0, 1));
        tick();
      end
      chk("rnd_drained", 64'(busy), 64'd0);
      ticks(3);
    end
    mon_en = 1'b0;
    chk("rnd_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("rnd_no_overrun",  64'(overrun),      64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/nios2_cpu_cpu_debug_cmd_bridge.md
Name: nios2_cpu_cpu_debug_cmd_bridge

Overview:
Multi-channel successor to the single-instance debug-slave system-clock side. It takes update-DR/update-IR events and shift-register snapshots from NUM_CH virtual-JTAG debug channels, synchronises them into the CPU clock domain and holds one pending command per channel. A round-robin arbiter serialises the pending commands onto a single valid/ready command port for the OCI break/ocimem/trace decode logic. Lost events are flagged per channel.

Parameters:
NUM_CH, 2, number of debug channels (1..8)
SR_W, 38, shift-register / command data width
IR_W, 2, virtual IR width per channel
SYNC_STAGES, 2, synchroniser flops per event input (2..4)
CH_W, 1, channel index width, max(1, clog2(NUM_CH))

Ports:
clk  in  1  CPU system clock
reset_n  in  1  asynchronous active-low reset
ch_udr  in  NUM_CH  per-channel update-DR level from the TCK domain
ch_uir  in  NUM_CH  per-channel update-IR level from the TCK domain
ch_ir  in  NUM_CH*IR_W  per-channel IR value, channel k at [k*IR_W +: IR_W]
ch_sr  in  NUM_CH*SR_W  per-channel shift register, channel k at [k*SR_W +: SR_W]
cmd_valid  out  1  command available
cmd_ready  in  1  consumer accepts command
cmd_ch  out  CH_W  source channel
cmd_kind  out  1  0 = DR update, 1 = IR update
cmd_ir  out  IR_W  IR captured with the command
cmd_data  out  SR_W  captured SR for DR updates; 0 for IR updates
overrun  out  NUM_CH  sticky per-channel event-lost flag
overrun_clr  in  NUM_CH  per-bit clear of overrun
busy  out  1  any slot pending or cmd_valid high

Behaviour:
- Single clock domain: clk. Reset is asynchronous and active-low on reset_n. All flops reset to 0. At reset, cmd_valid, cmd_ch, cmd_kind, cmd_ir, cmd_data, overrun and busy are all 0.
- Each ch_udr and ch_uir bit passes through SYNC_STAGES flops. A registered rising-edge detect follows. An input already high at reset release yields exactly one event.
- Source contract: ch_sr and ch_ir stay stable for at least SYNC_STAGES+2 clk after the udr/uir rise. The block does not check this.
- Slot per channel holds {valid, kind, ir, data}.
  - DR edge: load kind=0, ir=ch_ir, data=ch_sr.
  - IR edge: load kind=1, ir=ch_ir, data=0.
- Simultaneous DR and IR edges on one channel in one cycle: DR is loaded, and the IR event counts as lost (overrun set).
- Edge arriving while the slot is valid and the slot is not being drained in that cycle: the event is dropped, the old contents are kept, and overrun[k] is set.
- Edge arriving in the same cycle the slot drains: the new event loads and there is no overrun.
- overrun[k]: set has priority over overrun_clr[k] in the same cycle.
- Output register:
  - Loads from the arbiter winner when cmd_valid=0, or when cmd_valid & cmd_ready (back-to-back, no bubble).
  - The winner's slot clears in that same cycle.
  - While cmd_valid=1 and cmd_ready=0, all cmd_* outputs hold stable.
  - cmd_ready while cmd_valid=0 is ignored.
- Arbiter: round-robin over valid slots, starting at rr_ptr.
  - On each load, rr_ptr becomes winner+1, wrapping at NUM_CH-1 -> 0.
  - Reset value of rr_ptr is 0.
  - NUM_CH=1 degenerates to a pass-through with no arbitration.
- Latency, idle, cmd_ready=1: rising edge sampled at cycle 0 -> slot valid at cycle SYNC_STAGES+1 -> cmd_valid at SYNC_STAGES+2 (4 for the default).
- Throughput: one command per clk.
- busy = OR(slot valid) | cmd_valid.
- Reset asserted mid-transaction: all pending slots, the output register and overrun clear immediately. Events in flight are lost without any overrun indication.

Test Plan:
- Reset/idle: hold reset_n=0 with random inputs -> all outputs 0. Release with all ch_* low -> cmd_valid stays 0 and busy=0 for 20 clk.
- Single DR latency: ch_sr[0]=38'h2A_DEAD_BEEF, ch_ir[0]=2'b01, ch_udr[0] rises at cycle 0, cmd_ready=1 -> cmd_valid=1 at cycle 4 for exactly 1 clk with cmd_ch=0, cmd_kind=0, cmd_ir=1, cmd_data=38'h2A_DEAD_BEEF.
- Round-robin: NUM_CH=2, both channels raise udr in the same cycle, cmd_ready=1 -> ch0 is issued, then ch1 on the next clk. Repeat with both again -> ch0 is first again, because rr_ptr has wrapped back to 0.
- Backpressure/overrun: cmd_ready=0; channel 0 sends DR A, then DR B (slot full), then DR C -> overrun[0]=1 and B is held in the slot, C is dropped. cmd_* stays A until cmd_ready=1, then B is issued. overrun_clr[0] pulse -> overrun[0]=0.
- IR event and simultaneous set/clear: ch_uir[1] rises with ch_ir[1]=2'b10 -> cmd_kind=1, cmd_ir=2, cmd_data=0. In a cycle where an overrun event coincides with overrun_clr[1]=1 -> overrun[1]=1.
- Reset mid-operation: two slots pending, cmd_valid=1, cmd_ready=0; assert reset_n=0 for 1 clk -> cmd_valid=0, busy=0, overrun=0. No stale command appears after release.
